mux_scan_ctrl: RTL

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_if.sv | 22 ++
 rtl/mux_scan_ctrl.sv | 89 ++++++++
 2 files changed

// File: rtl/mux_scan_if.sv
// Handshake and mux-select bundle between mux_scan_ctrl and its environment.
// The master modport is the scan controller; the slave modport is the requester, consumer and mux side.
interface mux_scan_if;
    logic        start;
    logic        cont;
    logic        mux_in;
    logic        data_ready;
    logic [3:0]  sel;
    logic [15:0] data;
    logic        data_valid;
    logic        busy;

    modport master (
        input  start, cont, mux_in, data_ready,
        output sel, data, data_valid, busy
    );

    modport slave (
        output start, cont, mux_in, data_ready,
        input  sel, data, data_valid, busy
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps a 4-bit select through an external 16:1 mux and assembles the sampled bits into a word.
// Each channel waits SETTLE cycles before it is sampled. The finished word is offered on a valid/ready handshake.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    mux_scan_if.master bus
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } state_t;

    state_t      state;
    logic [3:0]  settle_cnt;
    logic [15:0] shadow;

    // NOTE: every register below uses non-blocking assignment, so all branches read pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            settle_cnt      <= 4'd0;
            shadow          <= 16'h0000;
            bus.sel         <= 4'd0;
            bus.data        <= 16'h0000;
            bus.data_valid  <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= SCAN;
                        bus.busy   <= 1'b1;
                        bus.sel    <= 4'd0;
                        settle_cnt <= 4'd0;
                        shadow     <= 16'h0000;
                    end
                end

                SCAN: begin
                    if (settle_cnt != SETTLE_CNT) begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end else begin
                        settle_cnt          <= 4'd0;
                        shadow[bus.sel]     <= bus.mux_in;
                        if (bus.sel == 4'd15) begin
                            // The last bit has not reached the shadow yet, so it is merged in directly.
                            bus.data       <= {bus.mux_in, shadow[14:0]};
                            bus.data_valid <= 1'b1;
                            bus.sel        <= 4'd0;
                            bus.busy       <= 1'b0;
                            state          <= HOLD;
                        end else begin
                            bus.sel <= bus.sel + 4'd1;
                        end
                    end
                end

                HOLD: begin
                    if (bus.data_valid && bus.data_ready) begin
                        bus.data_valid <= 1'b0;
                        if (bus.cont) begin
                            state      <= SCAN;
                            bus.busy   <= 1'b1;
                            bus.sel    <= 4'd0;
                            settle_cnt <= 4'd0;
                            shadow     <= 16'h0000;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state          <= IDLE;
                    bus.busy       <= 1'b0;
                    bus.sel        <= 4'd0;
                    bus.data_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
